store_hash_tracker: RTL and testbench

STORE_HASH_TRACKER -- requirements
Module: store_hash_tracker

---
 rtl/store_hash_tracker_pkg.sv | 11 +
 rtl/store_hash_tracker_if.sv | 31 +++
 rtl/store_hash_tracker_addr_fold_hash.sv | 26 ++
 rtl/store_hash_tracker.sv | 77 +++++++
 tb/tb_store_hash_tracker.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/store_hash_tracker_pkg.sv
// store_hash_tracker_pkg: shared hash width type and default fold/tracker constants
package store_hash_tracker_pkg;

    localparam int HASH_W_DEF  = 4;
    localparam int ADDR_LO_DEF = 2;
    localparam int ADDR_HI_DEF = 11;
    localparam int DEPTH_DEF   = 4;

    typedef logic [HASH_W_DEF-1:0] hash_t;

endpackage

// File: rtl/store_hash_tracker_if.sv
// store_hash_tracker_if: alloc/release/flush/lookup bundle between a core and the tracker
interface store_hash_tracker_if import store_hash_tracker_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int IW = $clog2(DEPTH);

    logic          alloc_valid;
    logic [31:0]   alloc_addr;
    logic          alloc_ready;
    logic [IW-1:0] alloc_id;
    logic          release_valid;
    logic [IW-1:0] release_id;
    logic          flush;
    logic          lookup_valid;
    logic [31:0]   lookup_addr;
    logic          lookup_done;
    logic          lookup_hit;
    logic [DEPTH-1:0] lookup_match;
    logic [IW:0]   occupancy;

    modport master (
        output alloc_valid, alloc_addr, release_valid, release_id, flush, lookup_valid, lookup_addr,
        input  alloc_ready, alloc_id, lookup_done, lookup_hit, lookup_match, occupancy
    );

    modport slave (
        input  alloc_valid, alloc_addr, release_valid, release_id, flush, lookup_valid, lookup_addr,
        output alloc_ready, alloc_id, lookup_done, lookup_hit, lookup_match, occupancy
    );

endinterface

// File: rtl/store_hash_tracker_addr_fold_hash.sv
// addr_fold_hash: XOR-folds an address bit field into a HASH_W-bit hash
module addr_fold_hash import store_hash_tracker_pkg::*; #(
    parameter int HASH_W  = HASH_W_DEF,
    parameter int ADDR_LO = ADDR_LO_DEF,
    parameter int ADDR_HI = ADDR_HI_DEF
) (
    input  logic [31:0]       addr_i,
    output logic [HASH_W-1:0] hash_o
);
    localparam int FW = ADDR_HI - ADDR_LO + 1;
    localparam int NC = (FW + HASH_W - 1) / HASH_W;

    logic [NC*HASH_W-1:0] field;
    logic                 unused_addr;

    assign unused_addr = ^addr_i;

    // zero-pad the field to whole chunks and XOR them together, chunk 0 at ADDR_LO
    always_comb begin
        field = '0;
        field[FW-1:0] = addr_i[ADDR_HI:ADDR_LO];
        hash_o = '0;
        for (int i = 0; i < NC; i++) hash_o = hash_o ^ field[i*HASH_W +: HASH_W];
    end

endmodule

// File: rtl/store_hash_tracker.sv
// store_hash_tracker: tracks in-flight store address hashes and flags possible load conflicts
module store_hash_tracker import store_hash_tracker_pkg::*; #(
    parameter int HASH_W  = HASH_W_DEF,
    parameter int ADDR_LO = ADDR_LO_DEF,
    parameter int ADDR_HI = ADDR_HI_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input logic clk,
    input logic rst,
    store_hash_tracker_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d, match_q, match_d, alloc_mask, rel_mask;
    logic [HASH_W-1:0] hash_q [DEPTH];
    logic [HASH_W-1:0] a_hash, l_hash;
    logic [IW:0]       occ_q, occ_d;
    logic              done_q, hit_q, alloc_acc;
    logic [IW-1:0]     free_id;

    addr_fold_hash #(.HASH_W(HASH_W), .ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)) u_alloc_hash (
        .addr_i(bus.alloc_addr), .hash_o(a_hash)
    );

    addr_fold_hash #(.HASH_W(HASH_W), .ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)) u_lookup_hash (
        .addr_i(bus.lookup_addr), .hash_o(l_hash)
    );

    // lowest-index free entry, scanned downward so the lowest one wins
    always_comb begin
        free_id = '0;
        for (int i = DEPTH - 1; i >= 0; i--) free_id = valid_q[i] ? free_id : IW'(i);
    end

    assign alloc_acc = bus.alloc_valid & bus.alloc_ready & ~bus.flush;

    // next valid set, occupancy and lookup match; selection and match use pre-release state
    always_comb begin
        alloc_mask = alloc_acc ? {{(DEPTH-1){1'b0}}, 1'b1} << free_id : '0;
        rel_mask = bus.release_valid ? {{(DEPTH-1){1'b0}}, 1'b1} << bus.release_id : '0;
        valid_d = bus.flush ? '0 : (valid_q & ~rel_mask) | alloc_mask;
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) occ_d = occ_d + {{IW{1'b0}}, valid_d[i]};
        for (int i = 0; i < DEPTH; i++)
            match_d[i] = bus.lookup_valid & ((valid_q[i] & (hash_q[i] == l_hash)) | (alloc_mask[i] & (a_hash == l_hash)));
    end

    // control state and registered lookup result, dropped immediately on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            match_q <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            match_q <= match_d;
            hit_q   <= |match_d;
            done_q  <= bus.lookup_valid;
            occ_q   <= occ_d;
        end
    end

    // hash payload needs no reset: it is only observed through its valid bit
    always_ff @(posedge clk) begin
        if (alloc_acc) hash_q[free_id] <= a_hash;
    end

    assign bus.alloc_ready  = ~&valid_q;
    assign bus.alloc_id     = free_id;
    assign bus.lookup_done  = done_q;
    assign bus.lookup_hit   = hit_q;
    assign bus.lookup_match = match_q;
    assign bus.occupancy    = occ_q;

endmodule

// File: tb/tb_store_hash_tracker.sv
// tb_store_hash_tracker: scoreboard bench for store_hash_tracker with default parameters
module tb_store_hash_tracker;
    import store_hash_tracker_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] m_valid = '0;
    hash_t      m_hash [4];
    logic [3:0] sb [$];

    store_hash_tracker_if #(.DEPTH(4)) bus ();

    store_hash_tracker #(.HASH_W(4), .ADDR_LO(2), .ADDR_HI(11), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic hash_t mh(input logic [31:0] a);
        return {a[5]^a[9], a[4]^a[8], a[3]^a[7]^a[11], a[2]^a[6]^a[10]};
    endfunction

    task automatic idle();
        bus.alloc_valid = 0; bus.alloc_addr = '0; bus.release_valid = 0; bus.release_id = '0;
        bus.flush = 0; bus.lookup_valid = 0; bus.lookup_addr = '0;
    endtask

    task automatic step(input logic av, input logic [31:0] aa, input logic rv, input logic [1:0] rid,
                        input logic fl, input logic lv, input logic [31:0] la);
        logic rdy, acc;
        logic [1:0] id;
        logic [3:0] am, rm, em, got;
        bus.alloc_valid = av; bus.alloc_addr = aa; bus.release_valid = rv; bus.release_id = rid;
        bus.flush = fl; bus.lookup_valid = lv; bus.lookup_addr = la;
        rdy = ~&m_valid;
        id = 2'd0;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) id = 2'(i);
        chk("alloc_ready", {31'd0, bus.alloc_ready}, {31'd0, rdy});
        chk("alloc_id", {30'd0, bus.alloc_id}, {30'd0, id});
        acc = av & rdy & ~fl;
        am = acc ? 4'b0001 << id : 4'b0000;
        rm = rv ? 4'b0001 << rid : 4'b0000;
        for (int i = 0; i < 4; i++)
            em[i] = lv && ((m_valid[i] && m_hash[i] == mh(la)) || (am[i] && mh(aa) == mh(la)));
        if (lv) sb.push_back(em);
        if (acc) m_hash[id] = mh(aa);
        m_valid = fl ? 4'b0000 : (m_valid & ~rm) | am;
        @(posedge clk);
        #1;
        chk("lookup_done", {31'd0, bus.lookup_done}, {31'd0, lv});
        if (bus.lookup_done) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                got = sb.pop_front();
                chk("lookup_match", {28'd0, bus.lookup_match}, {28'd0, got});
                chk("lookup_hit", {31'd0, bus.lookup_hit}, {31'd0, |got});
            end
        end else begin
            chk("idle_match", {28'd0, bus.lookup_match}, 32'd0);
            chk("idle_hit", {31'd0, bus.lookup_hit}, 32'd0);
        end
        chk("occupancy", {29'd0, bus.occupancy}, $countones(m_valid));
        idle();
    endtask

    initial begin
        idle();
        #3;
        chk("rst_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk("rst_id", {30'd0, bus.alloc_id}, 32'd0);
        chk("rst_occ", {29'd0, bus.occupancy}, 32'd0);
        chk("rst_done", {31'd0, bus.lookup_done}, 32'd0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;
        // alias hit: 0x44 and 0x0 both fold to hash 0
        step(1, 32'h0000_0044, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h0000_0000);
        chk("alias_hit", {31'd0, bus.lookup_hit}, 32'd1);
        chk("alias_match", {28'd0, bus.lookup_match}, 32'h1);
        step(0, 0, 0, 0, 1, 0, 0);
        // distinct hashes miss
        step(1, 32'h1000_0004, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h0000_0008);
        chk("miss_hit", {31'd0, bus.lookup_hit}, 32'd0);
        step(0, 0, 0, 0, 1, 0, 0);
        // fill, overflow attempt, release 2 and reuse it
        for (int k = 0; k < 4; k++) step(1, 32'h100 * k, 0, 0, 0, 0, 0);
        chk("full_occ", {29'd0, bus.occupancy}, 32'd4);
        step(1, 32'h0000_0ffc, 0, 0, 0, 1, 32'h0000_0ffc);
        step(0, 0, 1, 2, 0, 0, 0);
        chk("reuse_id", {30'd0, bus.alloc_id}, 32'd2);
        step(1, 32'h0000_0020, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        // bypass and release-does-not-mask
        step(1, 32'h0000_0044, 0, 0, 0, 1, 32'h0000_0000);
        chk("bypass_match", {28'd0, bus.lookup_match}, 32'h1);
        step(0, 0, 1, 0, 0, 1, 32'h0000_0000);
        chk("rel_hit", {31'd0, bus.lookup_hit}, 32'd1);
        // flush wins over alloc
        for (int k = 0; k < 4; k++) step(1, 32'h40 * k, 0, 0, 0, 0, 0);
        step(1, 32'h0000_0010, 0, 0, 1, 1, 32'h0000_0000);
        chk("flush_occ", {29'd0, bus.occupancy}, 32'd0);
        chk("flush_ready", {31'd0, bus.alloc_ready}, 32'd1);
        // random traffic over a small address pool to get frequent hits
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pool [5];
            pool[0] = 32'h44; pool[1] = 32'h0; pool[2] = 32'h8; pool[3] = 32'h1000_0004; pool[4] = $urandom;
            step($urandom_range(0, 1), pool[$urandom_range(0, 4)], $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1), pool[$urandom_range(0, 4)]);
        end
        // asynchronous reset drops a pending lookup result mid-cycle
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 32'h0000_0044, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h0000_0000);
        #2 rst = 1'b0;
        #1;
        chk("arst_done", {31'd0, bus.lookup_done}, 32'd0);
        chk("arst_hit", {31'd0, bus.lookup_hit}, 32'd0);
        chk("arst_match", {28'd0, bus.lookup_match}, 32'd0);
        chk("arst_occ", {29'd0, bus.occupancy}, 32'd0);
        chk("arst_ready", {31'd0, bus.alloc_ready}, 32'd1);
        m_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1, 32'h0000_0008, 0, 0, 0, 1, 32'h0000_0008);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("sb_drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
